writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Registered WB stage with one register-file write port. Formats raw load words
//  (byte/half select, sign/zero extend) and merges a second, out-of-band result
//  source (multi-cycle MDU/CSR unit) through a small pending FIFO. The pipeline
//  source always has priority. Queued results drain only in cycles where the
//  pipeline does not write.
// PARAMETERS
//  XLEN       32  data width
//  RADDR_W    5   register address width
//  ALT_DEPTH  4   alternate-source FIFO entries (power of 2, >=2)
// PORTS
//  clk              in   1        clock, rising edge
//  rst_n            in   1        asynchronous active-low reset
//  rd_valid_in      in   1        pipeline instruction writes rd
//  rd_addr_in       in   RADDR_W  pipeline destination
//  rd_value_in      in   XLEN     ALU/other result
//  mem_data_in      in   XLEN     raw aligned memory word
//  mem_addr_lo_in   in   2        load byte offset (addr[1:0])
//  instr_id_in      in   6        instruction id (INSTR_* from instr_defines.vh)
//  alt_valid_in     in   1        alternate result offered
//  alt_ready_out    out  1        alternate result accepted when valid&ready
//  alt_rd_addr_in   in   RADDR_W  alternate destination
//  alt_rd_value_in  in   XLEN     alternate result
//  pend_addr_in     in   RADDR_W  hazard query register
//  pend_hit_out     out  1        valid queued entry targets pend_addr_in (comb)
//  stall_req_out    out  1        FIFO full; pipeline must hold/bubble (comb)
//  wr_en_out        out  1        register-file write enable (registered)
//  rd_addr_out      out  RADDR_W  write address (registered)
//  rd_value_out     out  XLEN     write data (registered)
// BEHAVIOUR
//  Reset: wr_en_out=0, rd_addr_out=0, rd_value_out=0, FIFO empty, all entry valids 0.
//   Reset mid-operation discards queued entries without writing them.
//  Pipeline write (pw) = rd_valid_in & (rd_addr_in!=0). If pw in cycle N, then at
//   cycle N+1: wr_en_out=1 with the formatted value.
//  Load formatting: LB/LBU pick byte mem_addr_lo_in; LH/LHU pick half
//   mem_addr_lo_in[1] (bit0 ignored); LW takes the full word. LB/LH sign-extend,
//   LBU/LHU zero-extend. Non-loads use rd_value_in.
//  alt_ready_out = !full (no same-cycle refill when full). Accept at N: entry is
//   in the FIFO at N+1; earliest write is at N+2.
//  Entries with alt_rd_addr_in==0 are stored invalid.
//  Drain: when !pw and FIFO non-empty, pop head. A valid head gives
//   wr_en_out=1 in the next cycle; an invalid head is popped silently (wr_en_out=0).
//   An invalid head may also pop while pw=1, since it uses no write port.
//  Kill rule: a pipeline result is younger than any queued alternate result.
//   On pw to rd X, clear the valid bit of every queued entry with rd X. An entry
//   accepted in the same cycle with rd X is stored invalid.
//  Simultaneous accept and pop: allowed; count is unchanged; pointers wrap mod ALT_DEPTH.
//  stall_req_out = (count==ALT_DEPTH).
//  pend_hit_out = (pend_addr_in!=0) & any valid entry with matching rd.
//  When neither pw nor a valid pop occurs: wr_en_out=0; rd_addr_out and rd_value_out hold.
// TESTING
//  LB, mem_data_in=0x80FF7F01, offset 3, rd=5 -> next cycle wr_en=1, x5=0xFFFFFF80;
//   same word LHU offset 2 -> 0x000080FF.
//  rd_valid_in=1, rd_addr_in=0 -> wr_en_out stays 0.
//  alt push rd=7 val=0x1234 while pipeline idle -> wr_en=1, x7=0x1234 exactly 2
//   cycles after accept.
//  Pipeline writes every cycle, push 4 alt entries -> stall_req_out=1,
//   alt_ready_out=0; one pipeline bubble -> head drains and stall drops next cycle.
//  Queue alt rd=9, then pipeline writes rd=9 -> pend_hit_out(9) goes 1->0; the
//   queued rd=9 entry is never written; x9 holds the pipeline value.
//  Assert rst_n=0 with 3 queued entries -> outputs 0 immediately; after release,
//   no writes and alt_ready_out=1.

Source files
------------

// File: rtl/writeback_unit.sv
// Registered writeback stage: formats load data and merges a queued alternate
// result source onto the single register-file write port (pipeline has priority).
module writeback_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RADDR_W   = 5,
    parameter int unsigned ALT_DEPTH = 4,
    parameter logic [5:0]  INSTR_LB  = 6'd1,
    parameter logic [5:0]  INSTR_LH  = 6'd2,
    parameter logic [5:0]  INSTR_LW  = 6'd3,
    parameter logic [5:0]  INSTR_LBU = 6'd4,
    parameter logic [5:0]  INSTR_LHU = 6'd5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_valid_in,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic [XLEN-1:0]    rd_value_in,
    input  logic [XLEN-1:0]    mem_data_in,
    input  logic [1:0]         mem_addr_lo_in,
    input  logic [5:0]         instr_id_in,
    input  logic               alt_valid_in,
    output logic               alt_ready_out,
    input  logic [RADDR_W-1:0] alt_rd_addr_in,
    input  logic [XLEN-1:0]    alt_rd_value_in,
    input  logic [RADDR_W-1:0] pend_addr_in,
    output logic               pend_hit_out,
    output logic               stall_req_out,
    output logic               wr_en_out,
    output logic [RADDR_W-1:0] rd_addr_out,
    output logic [XLEN-1:0]    rd_value_out
);

    localparam int unsigned PTR_W = $clog2(ALT_DEPTH);

    logic [RADDR_W-1:0] ent_addr  [ALT_DEPTH];
    logic [XLEN-1:0]    ent_value [ALT_DEPTH];
    logic [ALT_DEPTH-1:0] ent_valid;
    logic [PTR_W-1:0]   head, tail;
    logic [PTR_W:0]     count;

    logic pw, full, empty, accept, pop, head_valid, acc_valid;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] fmt_value;

    assign pw         = rd_valid_in && (rd_addr_in != '0);
    assign full       = (count == (PTR_W+1)'(ALT_DEPTH));
    assign empty      = (count == '0);
    assign head_valid = ent_valid[head];
    assign accept     = alt_valid_in && !full;
    // Invalid heads need no write port, so they may pop under a pipeline write.
    assign pop        = !empty && (!pw || !head_valid);
    assign acc_valid  = (alt_rd_addr_in != '0) && !(pw && (alt_rd_addr_in == rd_addr_in));

    assign alt_ready_out = !full;
    assign stall_req_out = full;

    always_comb begin
        pend_hit_out = 1'b0;
        for (int unsigned i = 0; i < ALT_DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == pend_addr_in))
                pend_hit_out = 1'b1;
        end
        if (pend_addr_in == '0)
            pend_hit_out = 1'b0;
    end

    always_comb begin
        case (mem_addr_lo_in)
            2'd0:    ld_byte = mem_data_in[7:0];
            2'd1:    ld_byte = mem_data_in[15:8];
            2'd2:    ld_byte = mem_data_in[23:16];
            default: ld_byte = mem_data_in[31:24];
        endcase
        ld_half = mem_addr_lo_in[1] ? mem_data_in[31:16] : mem_data_in[15:0];
        case (instr_id_in)
            INSTR_LB:  fmt_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            INSTR_LBU: fmt_value = {{(XLEN-8){1'b0}}, ld_byte};
            INSTR_LH:  fmt_value = {{(XLEN-16){ld_half[15]}}, ld_half};
            INSTR_LHU: fmt_value = {{(XLEN-16){1'b0}}, ld_half};
            INSTR_LW:  fmt_value = mem_data_in;
            default:   fmt_value = rd_value_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            // A pipeline write is younger than anything queued: kill matching entries.
            for (int unsigned i = 0; i < ALT_DEPTH; i++) begin
                if (pw && (ent_addr[i] == rd_addr_in))
                    ent_valid[i] <= 1'b0;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (accept) begin
                ent_addr[tail]  <= alt_rd_addr_in;
                ent_value[tail] <= alt_rd_value_in;
                ent_valid[tail] <= acc_valid;
                tail            <= tail + 1'b1;
            end
            if (accept && !pop)
                count <= count + 1'b1;
            else if (!accept && pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_out    <= 1'b0;
            rd_addr_out  <= '0;
            rd_value_out <= '0;
        end else if (pw) begin
            wr_en_out    <= 1'b1;
            rd_addr_out  <= rd_addr_in;
            rd_value_out <= fmt_value;
        end else if (pop && head_valid) begin
            wr_en_out    <= 1'b1;
            rd_addr_out  <= ent_addr[head];
            rd_value_out <= ent_value[head];
        end else begin
            wr_en_out    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: load formatting, alternate
// queue latency, stall, kill rule and asynchronous reset.
module tb_writeback_unit;

    localparam logic [5:0] I_NONE = 6'd0;
    localparam logic [5:0] I_LB   = 6'd1;
    localparam logic [5:0] I_LH   = 6'd2;
    localparam logic [5:0] I_LW   = 6'd3;
    localparam logic [5:0] I_LBU  = 6'd4;
    localparam logic [5:0] I_LHU  = 6'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_valid_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] rd_value_in;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_addr_lo_in;
    logic [5:0]  instr_id_in;
    logic        alt_valid_in;
    logic        alt_ready_out;
    logic [4:0]  alt_rd_addr_in;
    logic [31:0] alt_rd_value_in;
    logic [4:0]  pend_addr_in;
    logic        pend_hit_out;
    logic        stall_req_out;
    logic        wr_en_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_value_out;

    int checks = 0;
    int failures = 0;

    writeback_unit #(.XLEN(32), .RADDR_W(5), .ALT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in), .rd_value_in(rd_value_in),
        .mem_data_in(mem_data_in), .mem_addr_lo_in(mem_addr_lo_in), .instr_id_in(instr_id_in),
        .alt_valid_in(alt_valid_in), .alt_ready_out(alt_ready_out),
        .alt_rd_addr_in(alt_rd_addr_in), .alt_rd_value_in(alt_rd_value_in),
        .pend_addr_in(pend_addr_in), .pend_hit_out(pend_hit_out), .stall_req_out(stall_req_out),
        .wr_en_out(wr_en_out), .rd_addr_out(rd_addr_out), .rd_value_out(rd_value_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] a, input logic [31:0] val,
                        input logic [5:0] id, input logic [1:0] lo);
        rd_valid_in    = v;
        rd_addr_in     = a;
        rd_value_in    = val;
        instr_id_in    = id;
        mem_addr_lo_in = lo;
    endtask

    task automatic alt(input logic v, input logic [4:0] a, input logic [31:0] val);
        alt_valid_in    = v;
        alt_rd_addr_in  = a;
        alt_rd_value_in = val;
    endtask

    task automatic expect_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] val);
        check_eq({tag, "_en"}, 32'(wr_en_out), 32'(en));
        check_eq({tag, "_addr"}, 32'(rd_addr_out), 32'(a));
        check_eq({tag, "_val"}, rd_value_out, val);
    endtask

    initial begin
        rst_n = 1'b0;
        pipe(1'b0, 5'd0, 32'h0, I_NONE, 2'd0);
        alt(1'b0, 5'd0, 32'h0);
        mem_data_in  = 32'h80FF7F01;
        pend_addr_in = 5'd0;
        #12;
        expect_wr("reset", 1'b0, 5'd0, 32'h0);
        check_eq("reset_stall", 32'(stall_req_out), 32'd0);
        check_eq("reset_ready", 32'(alt_ready_out), 32'd1);
        check_eq("reset_pend", 32'(pend_hit_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load formatting on word 0x80FF7F01
        pipe(1'b1, 5'd5, 32'hDEADBEEF, I_LB, 2'd3);  tick(); expect_wr("lb3",  1'b1, 5'd5, 32'hFFFFFF80);
        pipe(1'b1, 5'd6, 32'hDEADBEEF, I_LHU, 2'd2); tick(); expect_wr("lhu2", 1'b1, 5'd6, 32'h000080FF);
        pipe(1'b1, 5'd6, 32'hDEADBEEF, I_LH, 2'd3);  tick(); expect_wr("lh3",  1'b1, 5'd6, 32'hFFFF80FF);
        pipe(1'b1, 5'd6, 32'hDEADBEEF, I_LH, 2'd0);  tick(); expect_wr("lh0",  1'b1, 5'd6, 32'h00007F01);
        pipe(1'b1, 5'd8, 32'hDEADBEEF, I_LBU, 2'd1); tick(); expect_wr("lbu1", 1'b1, 5'd8, 32'h0000007F);
        pipe(1'b1, 5'd8, 32'hDEADBEEF, I_LW, 2'd2);  tick(); expect_wr("lw",   1'b1, 5'd8, 32'h80FF7F01);
        pipe(1'b1, 5'd8, 32'hDEADBEEF, I_NONE, 2'd3); tick(); expect_wr("alu", 1'b1, 5'd8, 32'hDEADBEEF);

        // Writes to x0 are suppressed; outputs hold
        pipe(1'b1, 5'd0, 32'h11111111, I_NONE, 2'd0); tick(); expect_wr("x0", 1'b0, 5'd8, 32'hDEADBEEF);

        // Alternate push, pipeline idle: write appears two cycles after accept
        pipe(1'b0, 5'd0, 32'h0, I_NONE, 2'd0);
        alt(1'b1, 5'd7, 32'h1234);
        tick();
        alt(1'b0, 5'd0, 32'h0);
        pend_addr_in = 5'd7;
        #1;
        check_eq("alt_n1_en", 32'(wr_en_out), 32'd0);
        check_eq("alt_pend7", 32'(pend_hit_out), 32'd1);
        tick();
        expect_wr("alt_n2", 1'b1, 5'd7, 32'h1234);
        check_eq("alt_pend7_gone", 32'(pend_hit_out), 32'd0);

        // Pipeline busy every cycle while four alternates fill the queue
        for (int i = 0; i < 4; i++) begin
            pipe(1'b1, 5'd1, 32'(i), I_NONE, 2'd0);
            alt(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            tick();
        end
        alt(1'b0, 5'd0, 32'h0);
        check_eq("full_stall", 32'(stall_req_out), 32'd1);
        check_eq("full_ready", 32'(alt_ready_out), 32'd0);
        expect_wr("full_pipe", 1'b1, 5'd1, 32'd3);
        pipe(1'b0, 5'd0, 32'h0, I_NONE, 2'd0);
        tick();
        check_eq("bubble_stall", 32'(stall_req_out), 32'd0);
        check_eq("bubble_ready", 32'(alt_ready_out), 32'd1);
        expect_wr("drain0", 1'b1, 5'd10, 32'hA0);
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_wr($sformatf("drain%0d", i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
        end
        tick();
        check_eq("drained_en", 32'(wr_en_out), 32'd0);

        // Kill rule: queued rd=9 superseded by pipeline write to rd=9
        pipe(1'b1, 5'd3, 32'h33, I_NONE, 2'd0);
        alt(1'b1, 5'd9, 32'h99);
        tick();
        alt(1'b0, 5'd0, 32'h0);
        pend_addr_in = 5'd9;
        #1;
        check_eq("kill_pend_before", 32'(pend_hit_out), 32'd1);
        pipe(1'b1, 5'd9, 32'h5555, I_NONE, 2'd0);
        tick();
        expect_wr("kill_pipe", 1'b1, 5'd9, 32'h5555);
        check_eq("kill_pend_after", 32'(pend_hit_out), 32'd0);
        pipe(1'b0, 5'd0, 32'h0, I_NONE, 2'd0);
        tick();
        expect_wr("kill_silent", 1'b0, 5'd9, 32'h5555);
        tick();
        check_eq("kill_idle_en", 32'(wr_en_out), 32'd0);

        // Same-cycle accept with pipeline write to the same rd is stored invalid
        pipe(1'b1, 5'd4, 32'h44, I_NONE, 2'd0);
        alt(1'b1, 5'd4, 32'h77);
        tick();
        pipe(1'b0, 5'd0, 32'h0, I_NONE, 2'd0);
        alt(1'b0, 5'd0, 32'h0);
        pend_addr_in = 5'd4;
        #1;
        expect_wr("same_pipe", 1'b1, 5'd4, 32'h44);
        check_eq("same_pend", 32'(pend_hit_out), 32'd0);
        tick();
        expect_wr("same_silent", 1'b0, 5'd4, 32'h44);

        // Alternate to x0 is stored invalid and never written
        alt(1'b1, 5'd0, 32'hBAD);
        tick();
        alt(1'b0, 5'd0, 32'h0);
        tick();
        expect_wr("alt_x0", 1'b0, 5'd4, 32'h44);

        // Asynchronous reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            pipe(1'b1, 5'd2, 32'h200 + 32'(i), I_NONE, 2'd0);
            alt(1'b1, 5'(20 + i), 32'hC0 + 32'(i));
            tick();
        end
        alt(1'b0, 5'd0, 32'h0);
        pend_addr_in = 5'd21;
        #1;
        check_eq("prerst_pend", 32'(pend_hit_out), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        expect_wr("midrst", 1'b0, 5'd0, 32'h0);
        check_eq("midrst_pend", 32'(pend_hit_out), 32'd0);
        pipe(1'b0, 5'd0, 32'h0, I_NONE, 2'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("postrst_en%0d", i), 32'(wr_en_out), 32'd0);
        end
        check_eq("postrst_ready", 32'(alt_ready_out), 32'd1);
        check_eq("postrst_addr", 32'(rd_addr_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end

endmodule
